// File: rtl/scma_pkg.sv
// Shared definitions for the CIM controller output path: serializer state encoding and
// the default output-FIFO / off-chip beat widths used on both sides of the FIFO.
package scma_pkg;

    localparam int SCMA_FIFO_WIDTH     = 64;
    localparam int SCMA_DATA_OUT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        BEAT0 = 3'd3,
        BEAT1 = 3'd4
    } state_e;

endpackage

// File: rtl/result_serializer.sv
// Drains 64-bit result words from the output FIFO and sends each as two 32-bit beats on a
// valid/ready bus, counting fully delivered words.
module result_serializer
    import scma_pkg::*;
#(
    parameter int FIFO_WIDTH     = SCMA_FIFO_WIDTH,
    parameter int DATA_OUT_WIDTH = SCMA_DATA_OUT_WIDTH,
    parameter int CNT_WIDTH      = 16,
    parameter bit MSW_FIRST      = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      empty_outputfifo,
    input  logic [FIFO_WIDTH-1:0]     q_outputfifo,
    output logic                      RD_EN_outputfifo,
    output logic [DATA_OUT_WIDTH-1:0] dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      dout_last,
    input  logic                      cnt_clr,
    output logic [CNT_WIDTH-1:0]      word_cnt,
    output logic                      busy
);

    if (FIFO_WIDTH != 2 * DATA_OUT_WIDTH) begin : g_bad_width
        $error("result_serializer: FIFO_WIDTH must equal 2*DATA_OUT_WIDTH");
    end

    state_e                    state_q;
    logic [FIFO_WIDTH-1:0]     hold_q;
    logic                      rd_en_q;
    logic [DATA_OUT_WIDTH-1:0] dout_q;
    logic                      valid_q;
    logic                      last_q;
    logic [CNT_WIDTH-1:0]      cnt_q;
    logic [CNT_WIDTH-1:0]      cnt_d;

    function automatic logic [DATA_OUT_WIDTH-1:0] half_of(input logic [FIFO_WIDTH-1:0] w,
                                                          input logic upper);
        return upper ? w[FIFO_WIDTH-1 -: DATA_OUT_WIDTH] : w[DATA_OUT_WIDTH-1:0];
    endfunction

    // Outputs are registered together with the state they belong to, so the beat mux is
    // evaluated on the state being entered: BEAT0 takes MSW_FIRST's half, BEAT1 the other.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            rd_en_q <= 1'b0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            rd_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty_outputfifo) begin
                        state_q <= READ;
                        rd_en_q <= 1'b1;
                    end
                end
                READ: state_q <= LOAD;
                LOAD: begin
                    hold_q  <= q_outputfifo;
                    dout_q  <= half_of(q_outputfifo, MSW_FIRST);
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                    state_q <= BEAT0;
                end
                BEAT0: begin
                    if (dout_ready) begin
                        dout_q  <= half_of(hold_q, !MSW_FIRST);
                        last_q  <= 1'b1;
                        state_q <= BEAT1;
                    end
                end
                BEAT1: begin
                    // The empty flag is only consulted here, once the held word is gone,
                    // so a prefetch can never overwrite an undelivered word.
                    if (dout_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (!empty_outputfifo) begin
                            state_q <= READ;
                            rd_en_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (state_q == BEAT1 && dout_ready) begin
            cnt_d = cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign RD_EN_outputfifo = rd_en_q;
    assign dout             = dout_q;
    assign dout_valid       = valid_q;
    assign dout_last        = last_q;
    assign word_cnt         = cnt_q;
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_result_serializer.sv
// Bench for result_serializer: two lockstep instances (LSW-first 16-bit count, MSW-first
// 3-bit count) share one FIFO model and are checked against a word-level scoreboard.
module tb_result_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        empty;
    logic [63:0] q_fifo;
    logic        ready;
    logic        cnt_clr;

    logic        rd0, v0, last0, busy0;
    logic [31:0] dout0;
    logic [15:0] cnt0;
    logic        rd1, v1, last1, busy1;
    logic [31:0] dout1;
    logic [2:0]  cnt1;

    int vectors     = 0;
    int miscompares = 0;
    int cycle       = 0;

    logic [63:0] fq[$];
    logic [63:0] exp_words[$];
    bit          beat_idx;
    logic [15:0] mcnt0;
    logic [2:0]  mcnt1;

    always #5 clk = ~clk;

    result_serializer #(
        .FIFO_WIDTH(64), .DATA_OUT_WIDTH(32), .CNT_WIDTH(16), .MSW_FIRST(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .empty_outputfifo(empty), .q_outputfifo(q_fifo),
        .RD_EN_outputfifo(rd0), .dout(dout0), .dout_valid(v0), .dout_ready(ready),
        .dout_last(last0), .cnt_clr(cnt_clr), .word_cnt(cnt0), .busy(busy0)
    );

    result_serializer #(
        .FIFO_WIDTH(64), .DATA_OUT_WIDTH(32), .CNT_WIDTH(3), .MSW_FIRST(1'b1)
    ) dut1 (
        .clk(clk), .rst(rst), .empty_outputfifo(empty), .q_outputfifo(q_fifo),
        .RD_EN_outputfifo(rd1), .dout(dout1), .dout_valid(v1), .dout_ready(ready),
        .dout_last(last1), .cnt_clr(cnt_clr), .word_cnt(cnt1), .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] w);
        fq.push_back(w);
        empty = 1'b0;
    endtask

    // One clock: snapshot pre-edge signals, then after the edge update the FIFO and the
    // word-level model and compare everything observable.
    task automatic tick();
        logic        p_rd, p_v, p_r, p_rs, p_cl, p_emp, p_l0, p_l1;
        logic [31:0] p_d0, p_d1;
        logic [63:0] w;
        bit          hs_last;
        p_rd = rd0;  p_v = v0;  p_r = ready;  p_rs = rst;  p_cl = cnt_clr;  p_emp = empty;
        p_d0 = dout0; p_d1 = dout1; p_l0 = last0; p_l1 = last1;
        @(posedge clk);
        #1;
        cycle++;
        hs_last = 1'b0;
        if (p_rd) begin
            check("rd_while_empty", p_emp, 0);
            check("rd_while_held", exp_words.size(), 0);
            if (fq.size() > 0) begin
                w = fq.pop_front();
                q_fifo = w;
                if (!p_rs) exp_words.push_back(w);
            end
        end
        if (p_rs) begin
            exp_words.delete();
            beat_idx = 1'b0;
            mcnt0 = '0;
            mcnt1 = '0;
        end else begin
            if (p_v && p_r) begin
                check("beat_has_word", exp_words.size() != 0, 1);
                if (exp_words.size() != 0) begin
                    w = exp_words[0];
                    check("beat_lsw_first", p_d0, beat_idx ? w[63:32] : w[31:0]);
                    check("beat_msw_first", p_d1, beat_idx ? w[31:0] : w[63:32]);
                    check("last_lsw_first", p_l0, beat_idx);
                    check("last_msw_first", p_l1, beat_idx);
                    if (beat_idx) begin
                        exp_words.delete(0);
                        hs_last = 1'b1;
                    end
                    beat_idx = !beat_idx;
                end
            end
            if (p_cl) begin
                mcnt0 = '0;
                mcnt1 = '0;
            end else if (hs_last) begin
                mcnt0 = mcnt0 + 16'd1;
                mcnt1 = mcnt1 + 3'd1;
            end
            if (p_v && !p_r) begin
                check("stall_valid", v0, 1);
                check("stall_dout", dout0, p_d0);
                check("stall_last", last0, p_l0);
            end
        end
        check("word_cnt0", cnt0, mcnt0);
        check("word_cnt1", cnt1, mcnt1);
        check("lockstep_rd", rd1, rd0);
        check("lockstep_valid", v1, v0);
        empty = (fq.size() == 0);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((fq.size() != 0 || busy0 || exp_words.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check(tag, n < 200, 1);
    endtask

    task automatic wait_beat(input logic want_last, input string tag);
        int n = 0;
        while (!(v0 === 1'b1 && last0 === want_last) && n < 20) begin
            tick();
            n++;
        end
        check(tag, n < 20, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] w;
        int          rd_cycles[$];
        int          nwrap;
        rst = 1'b1; empty = 1'b1; q_fifo = '0; ready = 1'b1; cnt_clr = 1'b0;
        beat_idx = 1'b0; mcnt0 = '0; mcnt1 = '0;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_valid", v0, 0);
        check("rst_rd", rd0, 0);
        check("rst_last", last0, 0);
        check("rst_dout", dout0, 0);
        check("rst_cnt", cnt0, 0);
        check("rst_busy", busy0, 0);
        check("rst_dout_msw", dout1, 0);

        // Single word, fixed latency and beat order for both half orderings.
        push(64'h1111_2222_3333_4444);
        tick();
        check("lat_rd_pulse", rd0, 1);
        check("lat_busy", busy0, 1);
        tick();
        check("lat_rd_single", rd0, 0);
        check("lat_no_valid_yet", v0, 0);
        tick();
        check("lat_valid_c3", v0, 1);
        check("b0_lsw_first", dout0, 32'h3333_4444);
        check("b0_msw_first", dout1, 32'h1111_2222);
        check("b0_last", last0, 0);
        tick();
        check("b1_lsw_first", dout0, 32'h1111_2222);
        check("b1_msw_first", dout1, 32'h3333_4444);
        check("b1_last", last0, 1);
        check("b1_last_msw", last1, 1);
        tick();
        check("w1_idle_valid", v0, 0);
        check("w1_idle_busy", busy0, 0);
        check("w1_cnt", cnt0, 16'd1);

        // Stall in BEAT0 with a second word waiting in the FIFO.
        ready = 1'b0;
        push({$urandom, $urandom});
        wait_beat(1'b0, "stall_reach_beat0");
        push({$urandom, $urandom});
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_no_rd", rd0, 0);
            check("stall_cnt", cnt0, 16'd1);
            check("stall_still_beat0", last0, 0);
        end
        ready = 1'b1;
        drain("stall_drain");
        check("stall_cnt_after", cnt0, 16'd3);

        // Three queued words back to back.
        for (int i = 0; i < 3; i++) push({$urandom, $urandom});
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rd0) rd_cycles.push_back(cycle);
        end
        check("three_rd_count", rd_cycles.size(), 3);
        if (rd_cycles.size() == 3) begin
            check("three_spacing_a", rd_cycles[1] - rd_cycles[0], 4);
            check("three_spacing_b", rd_cycles[2] - rd_cycles[1], 4);
        end
        check("three_cnt", cnt0, 16'd6);

        // Wrap of the 3-bit counter instance.
        nwrap = 2;
        for (int i = 0; i < nwrap; i++) push({$urandom, $urandom});
        drain("wrap_drain");
        check("wrap_cnt1", cnt1, 3'd0);
        check("wrap_cnt0", cnt0, 16'd8);

        // Clear on the same cycle as the BEAT1 handshake.
        push({$urandom, $urandom});
        wait_beat(1'b1, "clr_reach_beat1");
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_wins_cnt0", cnt0, 16'd0);
        check("clr_wins_cnt1", cnt1, 3'd0);
        drain("clr_drain");

        // Reset while stalled in BEAT1: held word dropped, next word fetched fresh.
        push(64'hAAAA_0001_AAAA_0002);
        push(64'hBBBB_0003_BBBB_0004);
        wait_beat(1'b0, "rst_reach_beat0");
        tick();
        ready = 1'b0;
        check("rst_in_beat1", last0, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", v0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_cnt", cnt0, 0);
        check("midrst_last", last0, 0);
        tick();
        check("midrst_fresh_rd", rd0, 1);
        ready = 1'b1;
        drain("midrst_drain");
        check("midrst_cnt_after", cnt0, 16'd1);

        // Random traffic, ready and clears.
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 2) == 0) push({$urandom, $urandom});
            ready   = ($urandom_range(0, 3) != 0);
            cnt_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        ready = 1'b1;
        cnt_clr = 1'b0;
        drain("random_drain");
        check("random_scoreboard_empty", exp_words.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
